// File: rtl/ppe_rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler: FSM state encoding
// and default width constants.
package ppe_rr_sched_pkg;

  typedef enum logic {
    SCHED_IDLE  = 1'b0,
    SCHED_GRANT = 1'b1
  } sched_state_t;

  localparam int SCHED_WIDTH_DEF   = 8;
  localparam int SCHED_LOG_W_DEF   = 3;
  localparam int SCHED_TIMEOUT_DEF = 255;

endpackage

// File: rtl/ppe_rr_sched_pick.sv
// rr_pick: combinational programmable priority encoder. Index ptr has the
// highest priority, then ptr+1 ... N-1, 0 ... ptr-1.
module rr_pick
  import ppe_rr_sched_pkg::*;
#(
  parameter int SCHED_WIDTH = SCHED_WIDTH_DEF,
  parameter int SCHED_LOG_W = SCHED_LOG_W_DEF
) (
  input  logic [SCHED_WIDTH-1:0] req,
  input  logic [SCHED_LOG_W-1:0] ptr,
  output logic [SCHED_WIDTH-1:0] pick,
  output logic [SCHED_LOG_W-1:0] index,
  output logic                   valid
);

  int j;

  always_comb begin
    pick  = '0;
    index = '0;
    valid = 1'b0;
    j     = 0;
    // Walk the ring starting at ptr; the first requester found wins.
    for (int k = 0; k < SCHED_WIDTH; k++) begin
      j = (int'(ptr) + k) % SCHED_WIDTH;
      if (!valid && req[j]) begin
        pick[j] = 1'b1;
        index   = SCHED_LOG_W'(j);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppe_rr_sched.sv
// Round-robin grant scheduler: holds a one-hot grant until done[gnt_id], then
// moves the pointer past the winner. Define PPE_RR_SCHED_TIMEOUT_EN for forced release.
module ppe_rr_sched
  import ppe_rr_sched_pkg::*;
#(
  parameter int SCHED_WIDTH   = SCHED_WIDTH_DEF,
  parameter int SCHED_LOG_W   = SCHED_LOG_W_DEF,
  parameter int SCHED_TIMEOUT = SCHED_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SCHED_WIDTH-1:0] req,
  input  logic [SCHED_WIDTH-1:0] done,
  output logic [SCHED_WIDTH-1:0] gnt,
  output logic [SCHED_LOG_W-1:0] gnt_id,
  output logic                   busy,
  output logic [SCHED_LOG_W-1:0] ptr,
  output logic                   timeout
);

  if (SCHED_WIDTH < 2 || SCHED_TIMEOUT < 1) begin : g_bad_cfg
    $error("ppe_rr_sched: SCHED_WIDTH must be >= 2 and SCHED_TIMEOUT >= 1");
  end

  sched_state_t           state_q, state_d;
  logic [SCHED_WIDTH-1:0] pick;
  logic [SCHED_LOG_W-1:0] pick_id;
  logic                   pick_vld;
  logic                   done_hit;
  logic                   forced;
  logic                   release_now;
  logic [SCHED_LOG_W-1:0] ptr_next;

  rr_pick #(
    .SCHED_WIDTH (SCHED_WIDTH),
    .SCHED_LOG_W (SCHED_LOG_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .index (pick_id),
    .valid (pick_vld)
  );

  assign done_hit = done[gnt_id];
  assign ptr_next = (gnt_id == SCHED_LOG_W'(SCHED_WIDTH - 1)) ? '0 : gnt_id + 1'b1;

`ifdef PPE_RR_SCHED_TIMEOUT_EN
  localparam int CNT_W = SCHED_LOG_W + 8;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // A done on the expiry cycle wins, so the release is reported as normal.
  assign forced = (state_q == SCHED_GRANT) && !done_hit &&
                  (hold_cnt == CNT_W'(SCHED_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forced;
      if (state_q == SCHED_IDLE) hold_cnt <= '0;
      else                       hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  // State and grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCHED_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      ptr     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SCHED_IDLE) begin
        gnt <= pick;
        if (pick_vld) gnt_id <= pick_id;
      end else if (release_now) begin
        gnt <= '0;
        ptr <= ptr_next;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_d     = state_q;
    release_now = 1'b0;
    case (state_q)
      SCHED_IDLE:  if (pick_vld) state_d = SCHED_GRANT;
      SCHED_GRANT: begin
        if (done_hit || forced) begin
          state_d     = SCHED_IDLE;
          release_now = 1'b1;
        end
      end
      default:     state_d = SCHED_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == SCHED_GRANT);
`ifdef PPE_RR_SCHED_TIMEOUT_EN
    timeout = timeout_q;
`else
    timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ppe_rr_sched.sv
// Directed bench for ppe_rr_sched (N=8) with a behavioural reference model
// checked every cycle plus literal expectations along the directed sequence.
module tb_ppe_rr_sched;

  localparam int N  = 8;
  localparam int LW = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  gnt;
  logic [LW-1:0] gnt_id;
  logic          busy;
  logic [LW-1:0] ptr;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  ppe_rr_sched #(
    .SCHED_WIDTH   (N),
    .SCHED_LOG_W   (LW),
    .SCHED_TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .ptr     (ptr),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: who holds the grant, where the pointer is, how long held.
  bit m_busy = 1'b0;
  int m_id   = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;
  bit m_to   = 1'b0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        int best, best_dist;
        best = -1; best_dist = N;
        for (int i = 0; i < N; i++) begin
          if (req[i] && ((i - m_ptr + N) % N) < best_dist) begin
            best_dist = (i - m_ptr + N) % N;
            best      = i;
          end
        end
        if (best >= 0) begin
          m_busy = 1'b1; m_id = best; m_cnt = 0;
        end
      end else if (done[m_id]) begin
        m_busy = 1'b0; m_ptr = (m_id + 1) % N;
      end
`ifdef PPE_RR_SCHED_TIMEOUT_EN
      else if (m_cnt == TO - 1) begin
        m_busy = 1'b0; m_ptr = (m_id + 1) % N; m_to = 1'b1;
      end
`endif
      else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_gnt",     32'(gnt),     m_busy ? (32'd1 << m_id) : 32'd0);
      chk("cyc_gnt_id",  32'(gnt_id),  32'(m_id));
      chk("cyc_busy",    32'(busy),    32'(m_busy));
      chk("cyc_ptr",     32'(ptr),     32'(m_ptr));
      chk("cyc_timeout", 32'(timeout), 32'(m_to));
    end
  end

  initial begin
    int e;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Idle after reset
    repeat (5) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'h00);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ptr", 32'(ptr), 32'd0);
    end

    // Basic grant, release, pointer advance
    req = 8'h24; step();
    chk("t2_gnt", 32'(gnt), 32'h04); chk("t2_id", 32'(gnt_id), 32'd2);
    done = 8'h04; step(); done = '0;
    chk("t2_rel_gnt", 32'(gnt), 32'h00); chk("t2_rel_ptr", 32'(ptr), 32'd3);
    step();
    chk("t2_gnt2", 32'(gnt), 32'h20); chk("t2_id2", 32'(gnt_id), 32'd5);
    done = 8'h20; req = '0; step(); done = '0;
    chk("t2_ptr6", 32'(ptr), 32'd6);

    // All requesting: grants rotate 6,7,0..7 with a bubble each time
    req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      e = (6 + k) % N;
      step();
      chk("rot_id", 32'(gnt_id), 32'(e));
      chk("rot_gnt", 32'(gnt), 32'd1 << e);
      done = N'(1) << e; step(); done = '0;
      chk("rot_bubble", 32'(gnt), 32'h00);
      chk("rot_ptr", 32'(ptr), 32'((e + 1) % N));
    end
    req = '0;
    chk("rot_wrap_ptr", 32'(ptr), 32'd0);

    // Foreign done bits and dropped req are ignored during a grant
    req = 8'h02; step();
    chk("t4_gnt", 32'(gnt), 32'h02);
    done = 8'hFD; req = '0; step();
    chk("t4_hold_gnt", 32'(gnt), 32'h02); chk("t4_hold_busy", 32'(busy), 32'd1);
    done = 8'h02; step(); done = '0;
    chk("t4_rel_gnt", 32'(gnt), 32'h00); chk("t4_rel_ptr", 32'(ptr), 32'd2);

    // Reset in the middle of a grant
    req = 8'h10; step();
    chk("t5_gnt", 32'(gnt), 32'h10);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_gnt", 32'(gnt), 32'h00); chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ptr", 32'(ptr), 32'd0);
    step();
    chk("t5_regnt", 32'(gnt), 32'h10);
    done = 8'h10; req = '0; step(); done = '0;
    chk("t5_ptr", 32'(ptr), 32'd5);

    // done while idle is ignored; done plus new req uses the updated pointer
    done = 8'hFF; step(); done = '0;
    chk("t6_idle_busy", 32'(busy), 32'd0); chk("t6_idle_ptr", 32'(ptr), 32'd5);
    req = 8'h01; step();
    chk("t6_gnt0", 32'(gnt), 32'h01);
    done = 8'h01; req = 8'h03; step(); done = '0;
    chk("t6_rel_gnt", 32'(gnt), 32'h00); chk("t6_rel_ptr", 32'(ptr), 32'd1);
    step();
    chk("t6_gnt1", 32'(gnt), 32'h02);
    done = 8'h02; req = '0; step(); done = '0;
    chk("t6_ptr2", 32'(ptr), 32'd2);

    // Grant with no done
    req = 8'h01; step(); req = '0;
    chk("t7_gnt", 32'(gnt), 32'h01);
`ifdef PPE_RR_SCHED_TIMEOUT_EN
    repeat (3) begin
      step();
      chk("t7_hold", 32'(gnt), 32'h01); chk("t7_no_to", 32'(timeout), 32'd0);
    end
    step();
    chk("t7_forced_gnt", 32'(gnt), 32'h00); chk("t7_to", 32'(timeout), 32'd1);
    chk("t7_forced_ptr", 32'(ptr), 32'd1);
    step();
    chk("t7_to_pulse", 32'(timeout), 32'd0);
    req = 8'h01; step(); req = '0;
    chk("t7b_gnt", 32'(gnt), 32'h01);
    repeat (3) step();
    done = 8'h01; step(); done = '0;
    chk("t7b_rel_gnt", 32'(gnt), 32'h00); chk("t7b_to", 32'(timeout), 32'd0);
    chk("t7b_ptr", 32'(ptr), 32'd1);
`else
    repeat (22) begin
      step();
      chk("t7_hold", 32'(gnt), 32'h01); chk("t7_no_to", 32'(timeout), 32'd0);
    end
    done = 8'h01; step(); done = '0;
    chk("t7_rel_ptr", 32'(ptr), 32'd1);
`endif

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppe_rr_sched.md
Name: ppe_rr_sched

Overview:
- Round-robin grant scheduler built around the programmable priority encoder.
- Shares one downstream resource among N requesters.
- Locks a one-hot grant until the granted requester signals completion, then advances the priority pointer to the index after the winner.
- Sits between the requester ports and the shared datapath. It is the sequencing layer the bare encoder lacks: grant hold, release handshake and pointer update.

Parameters:
- SCHED_WIDTH, 8: number of requesters N, must be ≥2.
- SCHED_LOG_W, 3: ceil(log2(N)); width of pointer and grant index.
- SCHED_TIMEOUT, 255: max cycles a grant may be held (used only with the optional feature); must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  SCHED_WIDTH  level requests, bit i = requester i.
- done  in  SCHED_WIDTH  release pulses; only done[gnt_id] is honoured.
- gnt  out  SCHED_WIDTH  registered one-hot grant; all-zero when idle.
- gnt_id  out  SCHED_LOG_W  binary index of the current or last grant.
- busy  out  1  high while a grant is held.
- ptr  out  SCHED_LOG_W  current highest-priority index.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Interface is fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: gnt=0, gnt_id=0, busy=0, ptr=0, timeout=0, state=IDLE, hold counter=0.
- Priority rule: ptr=p makes index p highest priority, then p+1 … N-1, 0 … p-1 (circular).

State machine, two states:
- IDLE:
  - If |req at the edge: gnt <= encoder(req, ptr), gnt_id <= its index, busy <= 1, go to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req==0: stay in IDLE, outputs unchanged except gnt=0.
- GRANT:
  - gnt and gnt_id held constant. req changes are ignored, including the granted requester dropping req; it must still pulse done.
  - On done[gnt_id]=1 at the edge: gnt <= 0, busy <= 0, ptr <= (gnt_id==N-1) ? 0 : gnt_id+1, go to IDLE.
  - done bits other than gnt_id are ignored.

Boundary conditions:
- Minimum one IDLE cycle between consecutive grants (one bubble).
- Pointer wrap: when gnt_id=N-1, ptr returns to 0.
- done and new req in the same cycle: release is taken; the new req is arbitrated next cycle with the updated ptr.
- done pulse while in IDLE: ignored.
- rst asserted while in GRANT: next edge forces the reset values; no done is required and ptr returns to 0.
- Only requesters with req=1 in the sampled cycle can win. gnt is never non-zero when busy=0.

Optional Feature:
- Macro: PPE_RR_SCHED_TIMEOUT_EN.
- Enabled:
  - A hold counter of SCHED_LOG_W+8 bits, sized to hold SCHED_TIMEOUT, clears on entry to GRANT and increments each GRANT cycle.
  - If the counter equals SCHED_TIMEOUT-1 and done[gnt_id]=0, perform a forced release exactly like a normal release (ptr advances past gnt_id) and pulse timeout=1 for that one cycle.
  - If done[gnt_id]=1 on that same cycle, it is a normal release with timeout=0.
- Disabled:
  - No counter is instantiated; timeout is tied to 0.
  - A grant is held indefinitely until done.

Decomposition:
- Shared package/header holds:
  - state encodings SCHED_IDLE=1'b0, SCHED_GRANT=1'b1;
  - default width constants.
- One sub-module: rr_pick, a combinational programmable priority encoder with inputs req and ptr and outputs one-hot pick, binary index and valid.
- The FSM, pointer and counter stay in ppe_rr_sched.

Test Plan (N=8):
- Reset then req=8'h00 for 5 cycles → gnt=0, busy=0, ptr=0 throughout.
- req=8'h24, ptr=0 → gnt=8'h04, gnt_id=2 one cycle later. Pulse done[2] → gnt=0 next cycle, ptr=3. Next cycle → gnt=8'h20, gnt_id=5.
- req=8'hFF held, done pulsed on every grant → grants cycle 0,1,…,7,0 with one idle cycle between each; ptr wraps 7→0.
- While gnt=8'h02: pulse done=8'hFD (all except bit 1) and drop req[1] → gnt remains 8'h02. Then done[1]=1 → release, ptr=2.
- Mid-grant (gnt=8'h10): assert rst for one cycle → next edge gnt=0, busy=0, ptr=0; with req=8'h10 still high, re-grant 8'h10 on the first cycle after rst deasserts.
- With PPE_RR_SCHED_TIMEOUT_EN and SCHED_TIMEOUT=4: grant 8'h01 with no done → forced release after 4 GRANT cycles, timeout=1 for exactly one cycle, ptr=1. Without the macro, gnt stays 8'h01 for 20+ cycles and timeout stays 0.
